// File: rtl/amba_axi4_lite_rr_arbiter.sv
// Two-manager AXI4-Lite round-robin arbiter onto a single subordinate.
// Write and read paths arbitrate independently, one transaction each.
module amba_axi4_lite_rr_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 64
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [1:0]                   M_AWVALID,
    output logic [1:0]                   M_AWREADY,
    input  logic [2*ADDRESS_WIDTH-1:0]   M_AWADDR,
    input  logic [5:0]                   M_AWPROT,
    input  logic [1:0]                   M_WVALID,
    output logic [1:0]                   M_WREADY,
    input  logic [2*DATA_WIDTH-1:0]      M_WDATA,
    input  logic [2*(DATA_WIDTH/8)-1:0]  M_WSTRB,
    output logic [1:0]                   M_BVALID,
    input  logic [1:0]                   M_BREADY,
    output logic [3:0]                   M_BRESP,
    input  logic [1:0]                   M_ARVALID,
    output logic [1:0]                   M_ARREADY,
    input  logic [2*ADDRESS_WIDTH-1:0]   M_ARADDR,
    input  logic [5:0]                   M_ARPROT,
    output logic [1:0]                   M_RVALID,
    input  logic [1:0]                   M_RREADY,
    output logic [2*DATA_WIDTH-1:0]      M_RDATA,
    output logic [3:0]                   M_RRESP,
    output logic                         S_AWVALID,
    input  logic                         S_AWREADY,
    output logic [ADDRESS_WIDTH-1:0]     S_AWADDR,
    output logic [2:0]                   S_AWPROT,
    output logic                         S_WVALID,
    input  logic                         S_WREADY,
    output logic [DATA_WIDTH-1:0]        S_WDATA,
    output logic [(DATA_WIDTH/8)-1:0]    S_WSTRB,
    input  logic                         S_BVALID,
    output logic                         S_BREADY,
    input  logic [1:0]                   S_BRESP,
    output logic                         S_ARVALID,
    input  logic                         S_ARREADY,
    output logic [ADDRESS_WIDTH-1:0]     S_ARADDR,
    output logic [2:0]                   S_ARPROT,
    input  logic                         S_RVALID,
    output logic                         S_RREADY,
    input  logic [DATA_WIDTH-1:0]        S_RDATA,
    input  logic [1:0]                   S_RRESP
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;
    logic    wgrant_q, wgrant_d;
    logic    rgrant_q, rgrant_d;
    logic    wptr_q, wptr_d;
    logic    rptr_q, rptr_d;
    logic    aw_done_q, aw_done_d;
    logic    w_done_q, w_done_d;

    logic w_addr, w_resp, r_addr, r_data;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Single requester wins outright; a tie goes to the pointer.
    function automatic logic pick(input logic [1:0] req, input logic ptr);
        pick = (req == 2'b11) ? ptr : req[1];
    endfunction

    function automatic logic [1:0] route(input logic en, input logic g);
        route = {en & g, en & ~g};
    endfunction

    assign w_addr = (wstate_q == W_ADDR);
    assign w_resp = (wstate_q == W_RESP);
    assign r_addr = (rstate_q == R_ADDR);
    assign r_data = (rstate_q == R_DATA);

    assign S_AWVALID = w_addr & M_AWVALID[wgrant_q] & ~aw_done_q;
    assign S_WVALID  = w_addr & M_WVALID[wgrant_q] & ~w_done_q;
    assign M_AWREADY = route(w_addr & ~aw_done_q & S_AWREADY, wgrant_q);
    assign M_WREADY  = route(w_addr & ~w_done_q & S_WREADY, wgrant_q);
    assign S_BREADY  = w_resp & M_BREADY[wgrant_q];
    assign M_BVALID  = route(w_resp & S_BVALID, wgrant_q);
    assign M_BRESP   = {2{S_BRESP}};

    assign S_ARVALID = r_addr & M_ARVALID[rgrant_q];
    assign M_ARREADY = route(r_addr & S_ARREADY, rgrant_q);
    assign S_RREADY  = r_data & M_RREADY[rgrant_q];
    assign M_RVALID  = route(r_data & S_RVALID, rgrant_q);
    assign M_RDATA   = {2{S_RDATA}};
    assign M_RRESP   = {2{S_RRESP}};

    assign aw_hs = S_AWVALID & S_AWREADY;
    assign w_hs  = S_WVALID & S_WREADY;
    assign b_hs  = S_BVALID & S_BREADY;
    assign ar_hs = S_ARVALID & S_ARREADY;
    assign r_hs  = S_RVALID & S_RREADY;

    // Payload follows the held grant, so it keeps the last winner while idle.
    assign S_AWADDR = wgrant_q ? M_AWADDR[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                               : M_AWADDR[ADDRESS_WIDTH-1:0];
    assign S_AWPROT = wgrant_q ? M_AWPROT[5:3] : M_AWPROT[2:0];
    assign S_WDATA  = wgrant_q ? M_WDATA[2*DATA_WIDTH-1:DATA_WIDTH]
                               : M_WDATA[DATA_WIDTH-1:0];
    assign S_WSTRB  = wgrant_q ? M_WSTRB[2*STRB_WIDTH-1:STRB_WIDTH]
                               : M_WSTRB[STRB_WIDTH-1:0];
    assign S_ARADDR = rgrant_q ? M_ARADDR[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                               : M_ARADDR[ADDRESS_WIDTH-1:0];
    assign S_ARPROT = rgrant_q ? M_ARPROT[5:3] : M_ARPROT[2:0];

    always_comb begin
        wstate_d  = wstate_q;
        wgrant_d  = wgrant_q;
        wptr_d    = wptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (wstate_q)
            W_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (|M_AWVALID) begin
                    wgrant_d = pick(M_AWVALID, wptr_q);
                    wstate_d = W_ADDR;
                end
            end
            W_ADDR: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) wstate_d = W_RESP;
            end
            W_RESP: begin
                if (b_hs) begin
                    wptr_d   = ~wgrant_q;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rgrant_d = rgrant_q;
        rptr_d   = rptr_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (|M_ARVALID) begin
                    rgrant_d = pick(M_ARVALID, rptr_q);
                    rstate_d = R_ADDR;
                end
            end
            R_ADDR: if (ar_hs) rstate_d = R_DATA;
            R_DATA: begin
                if (r_hs) begin
                    rptr_d   = ~rgrant_q;
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            wgrant_q  <= 1'b0;
            rgrant_q  <= 1'b0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            wgrant_q  <= wgrant_d;
            rgrant_q  <= rgrant_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_amba_axi4_lite_rr_arbiter.sv
// Directed bench for the two-manager AXI4-Lite round-robin arbiter.
// Each task drives one scenario cycle by cycle against hand-derived values.
module tb_amba_axi4_lite_rr_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic [1:0]        M_AWVALID = '0;
    logic [1:0]        M_AWREADY;
    logic [2*AW-1:0]   M_AWADDR = '0;
    logic [5:0]        M_AWPROT = '0;
    logic [1:0]        M_WVALID = '0;
    logic [1:0]        M_WREADY;
    logic [2*DW-1:0]   M_WDATA = '0;
    logic [2*SW-1:0]   M_WSTRB = '0;
    logic [1:0]        M_BVALID;
    logic [1:0]        M_BREADY = '0;
    logic [3:0]        M_BRESP;
    logic [1:0]        M_ARVALID = '0;
    logic [1:0]        M_ARREADY;
    logic [2*AW-1:0]   M_ARADDR = '0;
    logic [5:0]        M_ARPROT = '0;
    logic [1:0]        M_RVALID;
    logic [1:0]        M_RREADY = '0;
    logic [2*DW-1:0]   M_RDATA;
    logic [3:0]        M_RRESP;
    logic              S_AWVALID;
    logic              S_AWREADY = 1'b0;
    logic [AW-1:0]     S_AWADDR;
    logic [2:0]        S_AWPROT;
    logic              S_WVALID;
    logic              S_WREADY = 1'b0;
    logic [DW-1:0]     S_WDATA;
    logic [SW-1:0]     S_WSTRB;
    logic              S_BVALID = 1'b0;
    logic              S_BREADY;
    logic [1:0]        S_BRESP = '0;
    logic              S_ARVALID;
    logic              S_ARREADY = 1'b0;
    logic [AW-1:0]     S_ARADDR;
    logic [2:0]        S_ARPROT;
    logic              S_RVALID = 1'b0;
    logic              S_RREADY;
    logic [DW-1:0]     S_RDATA = '0;
    logic [1:0]        S_RRESP = '0;

    int chk = 0;
    int fails = 0;

    always #5 ACLK = ~ACLK;

    amba_axi4_lite_rr_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_AWADDR(M_AWADDR), .M_AWPROT(M_AWPROT),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
        .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BRESP(M_BRESP),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_AWADDR(S_AWADDR), .S_AWPROT(S_AWPROT),
        .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
        .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_BRESP(S_BRESP),
        .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_ARADDR(S_ARADDR), .S_ARPROT(S_ARPROT),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP)
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clr();
        M_AWVALID = '0; M_WVALID = '0; M_BREADY = '0;
        M_ARVALID = '0; M_RREADY = '0;
        S_AWREADY = 1'b0; S_WREADY = 1'b0; S_BVALID = 1'b0;
        S_ARREADY = 1'b0; S_RVALID = 1'b0;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        clr();
        tick();
        tick();
        ARESETn = 1'b1;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        M_AWVALID = 2'b11; M_WVALID = 2'b11; M_BREADY = 2'b11;
        M_ARVALID = 2'b11; M_RREADY = 2'b11;
        S_AWREADY = 1'b1; S_WREADY = 1'b1; S_BVALID = 1'b1;
        S_ARREADY = 1'b1; S_RVALID = 1'b1;
        tick();
        chk++; if (S_AWVALID !== 1'b0) begin fails++; $display("FAIL rst_s_awvalid: got %0h want 0", S_AWVALID); end
        chk++; if (S_WVALID !== 1'b0) begin fails++; $display("FAIL rst_s_wvalid: got %0h want 0", S_WVALID); end
        chk++; if (S_ARVALID !== 1'b0) begin fails++; $display("FAIL rst_s_arvalid: got %0h want 0", S_ARVALID); end
        chk++; if (S_BREADY !== 1'b0 || S_RREADY !== 1'b0) begin fails++; $display("FAIL rst_s_ready: got b=%0h r=%0h want 0", S_BREADY, S_RREADY); end
        chk++; if (M_AWREADY !== 2'b00 || M_WREADY !== 2'b00 || M_ARREADY !== 2'b00) begin fails++; $display("FAIL rst_m_ready: got aw=%0h w=%0h ar=%0h want 0", M_AWREADY, M_WREADY, M_ARREADY); end
        chk++; if (M_BVALID !== 2'b00 || M_RVALID !== 2'b00) begin fails++; $display("FAIL rst_m_valid: got b=%0h r=%0h want 0", M_BVALID, M_RVALID); end
        do_reset();
    endtask

    task automatic test_single_m1();
        do_reset();
        M_AWADDR = {32'h0000_0040, 32'h0};
        M_AWPROT = 6'b010_000;
        M_WDATA = {64'h1122_3344_5566_7788, 64'h0};
        M_WSTRB = {8'hF0, 8'h00};
        M_AWVALID = 2'b10; M_WVALID = 2'b10; M_BREADY = 2'b10;
        #1;
        chk++; if (S_AWVALID !== 1'b0) begin fails++; $display("FAIL m1_idle_awvalid: got %0h want 0", S_AWVALID); end
        tick();
        chk++; if (S_AWVALID !== 1'b1 || S_WVALID !== 1'b1) begin fails++; $display("FAIL m1_valid: got aw=%0h w=%0h want 1", S_AWVALID, S_WVALID); end
        chk++; if (S_AWADDR !== 32'h40) begin fails++; $display("FAIL m1_awaddr: got %0h want 40", S_AWADDR); end
        chk++; if (S_AWPROT !== 3'b010) begin fails++; $display("FAIL m1_awprot: got %0h want 2", S_AWPROT); end
        chk++; if (S_WDATA !== 64'h1122_3344_5566_7788 || S_WSTRB !== 8'hF0) begin fails++; $display("FAIL m1_wpayload: got %0h/%0h want 1122334455667788/f0", S_WDATA, S_WSTRB); end
        chk++; if (M_AWREADY !== 2'b00) begin fails++; $display("FAIL m1_awready_low: got %0h want 0", M_AWREADY); end
        S_AWREADY = 1'b1; S_WREADY = 1'b1;
        #1;
        chk++; if (M_AWREADY !== 2'b10 || M_WREADY !== 2'b10) begin fails++; $display("FAIL m1_ready_route: got aw=%0h w=%0h want 2", M_AWREADY, M_WREADY); end
        tick();
        M_AWVALID = 2'b00; M_WVALID = 2'b00;
        S_AWREADY = 1'b0; S_WREADY = 1'b0;
        S_BVALID = 1'b1; S_BRESP = 2'b00;
        #1;
        chk++; if (M_BVALID !== 2'b10 || M_BRESP !== 4'b0000) begin fails++; $display("FAIL m1_bresp: got v=%0h r=%0h want 2/0", M_BVALID, M_BRESP); end
        chk++; if (S_BREADY !== 1'b1) begin fails++; $display("FAIL m1_bready: got %0h want 1", S_BREADY); end
        tick();
        S_BVALID = 1'b0;
        #1;
        chk++; if (M_BVALID !== 2'b00) begin fails++; $display("FAIL m1_bvalid_end: got %0h want 0", M_BVALID); end
        chk++; if (S_AWADDR !== 32'h40) begin fails++; $display("FAIL m1_addr_hold: got %0h want 40", S_AWADDR); end
        clr();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int cyc[4];
        logic [3:0] gv = '0;
        do_reset();
        M_AWVALID = 2'b11; M_WVALID = 2'b11; M_BREADY = 2'b11;
        S_AWREADY = 1'b1; S_WREADY = 1'b1; S_BVALID = 1'b1;
        #1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            if (M_BVALID != 2'b00) begin
                gv = {gv[2:0], M_BVALID[1]};
                cyc[n] = c;
                n++;
            end
            tick();
        end
        chk++; if (n !== 4) begin fails++; $display("FAIL b2b_count: got %0d want 4", n); end
        chk++; if (gv !== 4'b0101) begin fails++; $display("FAIL b2b_order: got %b want 0101", gv); end
        for (int k = 0; k < 3; k++) begin
            chk++; if (n == 4 && cyc[k+1] - cyc[k] != 3) begin fails++; $display("FAIL b2b_gap%0d: got %0d want 3", k, cyc[k+1] - cyc[k]); end
        end
        clr();
    endtask

    task automatic test_wready_delay();
        do_reset();
        M_AWVALID = 2'b01; M_WVALID = 2'b01; M_BREADY = 2'b01;
        S_AWREADY = 1'b1;
        tick();
        chk++; if (S_AWVALID !== 1'b1 || S_WVALID !== 1'b1 || M_WREADY !== 2'b00) begin fails++; $display("FAIL wd_start: got aw=%0h w=%0h mw=%0h want 1/1/0", S_AWVALID, S_WVALID, M_WREADY); end
        tick();
        S_AWREADY = 1'b0;
        #1;
        chk++; if (S_AWVALID !== 1'b0 || S_WVALID !== 1'b1 || S_BREADY !== 1'b0) begin fails++; $display("FAIL wd_aw_done: got aw=%0h w=%0h b=%0h want 0/1/0", S_AWVALID, S_WVALID, S_BREADY); end
        tick();
        tick();
        S_WREADY = 1'b1;
        #1;
        chk++; if (M_WREADY !== 2'b01 || M_AWREADY !== 2'b00) begin fails++; $display("FAIL wd_wready: got w=%0h aw=%0h want 1/0", M_WREADY, M_AWREADY); end
        tick();
        S_WREADY = 1'b0; S_BVALID = 1'b1;
        #1;
        chk++; if (S_BREADY !== 1'b1 || M_BVALID !== 2'b01 || S_WVALID !== 1'b0) begin fails++; $display("FAIL wd_resp: got b=%0h mb=%0h w=%0h want 1/1/0", S_BREADY, M_BVALID, S_WVALID); end
        tick();
        S_BVALID = 1'b0; S_AWREADY = 1'b1; S_WREADY = 1'b1;
        #1;
        chk++; if (S_AWVALID !== 1'b0 || S_BREADY !== 1'b0) begin fails++; $display("FAIL wd_idle: got aw=%0h b=%0h want 0/0", S_AWVALID, S_BREADY); end
        tick();
        chk++; if (M_AWREADY !== 2'b01 || M_WREADY !== 2'b01) begin fails++; $display("FAIL wd_same_cycle: got aw=%0h w=%0h want 1/1", M_AWREADY, M_WREADY); end
        tick();
        M_AWVALID = 2'b00; M_WVALID = 2'b00;
        S_AWREADY = 1'b0; S_WREADY = 1'b0;
        #1;
        chk++; if (S_BREADY !== 1'b1 || S_AWVALID !== 1'b0) begin fails++; $display("FAIL wd_resp2: got b=%0h aw=%0h want 1/0", S_BREADY, S_AWVALID); end
        S_BVALID = 1'b1;
        tick();
        S_BVALID = 1'b0;
        #1;
        chk++; if (S_BREADY !== 1'b0) begin fails++; $display("FAIL wd_resp_once: got %0h want 0", S_BREADY); end
        tick();
        chk++; if (S_BREADY !== 1'b0 || S_AWVALID !== 1'b0) begin fails++; $display("FAIL wd_quiet: got b=%0h aw=%0h want 0/0", S_BREADY, S_AWVALID); end
        clr();
    endtask

    task automatic test_read_rr();
        do_reset();
        M_ARADDR = {32'h0000_0200, 32'h0000_0100};
        M_ARVALID = 2'b11; M_RREADY = 2'b11;
        S_ARREADY = 1'b1; S_RVALID = 1'b1;
        tick();
        chk++; if (S_ARADDR !== 32'h100 || M_ARREADY !== 2'b01) begin fails++; $display("FAIL rr_first: got addr=%0h ar=%0h want 100/1", S_ARADDR, M_ARREADY); end
        tick();
        chk++; if (M_RVALID !== 2'b01 || S_RREADY !== 1'b1) begin fails++; $display("FAIL rr_first_r: got rv=%0h rr=%0h want 1/1", M_RVALID, S_RREADY); end
        tick();
        chk++; if (M_RVALID !== 2'b00 || S_ARVALID !== 1'b0) begin fails++; $display("FAIL rr_idle: got rv=%0h ar=%0h want 0/0", M_RVALID, S_ARVALID); end
        tick();
        chk++; if (S_ARADDR !== 32'h200 || M_ARREADY !== 2'b10) begin fails++; $display("FAIL rr_second: got addr=%0h ar=%0h want 200/2", S_ARADDR, M_ARREADY); end
        tick();
        chk++; if (M_RVALID !== 2'b10) begin fails++; $display("FAIL rr_second_r: got %0h want 2", M_RVALID); end
        clr();
    endtask

    task automatic test_concurrent();
        logic [DW-1:0] rd1;
        do_reset();
        M_AWADDR = {32'h0, 32'h0000_0080};
        M_AWVALID = 2'b01; M_WVALID = 2'b01; M_BREADY = 2'b01;
        M_ARADDR = {32'h0000_0300, 32'h0};
        M_ARVALID = 2'b10; M_RREADY = 2'b10;
        S_AWREADY = 1'b1; S_WREADY = 1'b1; S_ARREADY = 1'b1;
        tick();
        chk++; if (S_AWADDR !== 32'h80 || S_ARADDR !== 32'h300) begin fails++; $display("FAIL cc_addr: got aw=%0h ar=%0h want 80/300", S_AWADDR, S_ARADDR); end
        chk++; if (M_AWREADY !== 2'b01 || M_ARREADY !== 2'b10) begin fails++; $display("FAIL cc_ready: got aw=%0h ar=%0h want 1/2", M_AWREADY, M_ARREADY); end
        tick();
        clr();
        M_BREADY = 2'b01; M_RREADY = 2'b10;
        S_BVALID = 1'b1; S_BRESP = 2'b00;
        S_RVALID = 1'b1; S_RDATA = 64'hDEAD_BEEF; S_RRESP = 2'b10;
        #1;
        rd1 = M_RDATA[2*DW-1:DW];
        chk++; if (M_RVALID !== 2'b10 || M_BVALID !== 2'b01) begin fails++; $display("FAIL cc_valid: got r=%0h b=%0h want 2/1", M_RVALID, M_BVALID); end
        chk++; if (rd1 !== 64'hDEAD_BEEF || M_RRESP !== 4'b1010) begin fails++; $display("FAIL cc_rdata: got %0h/%0h want deadbeef/a", rd1, M_RRESP); end
        chk++; if (S_RREADY !== 1'b1 || S_BREADY !== 1'b1) begin fails++; $display("FAIL cc_sready: got r=%0h b=%0h want 1/1", S_RREADY, S_BREADY); end
        tick();
        S_BVALID = 1'b0; S_RVALID = 1'b0;
        #1;
        chk++; if (M_RVALID !== 2'b00 || M_BVALID !== 2'b00) begin fails++; $display("FAIL cc_done: got r=%0h b=%0h want 0/0", M_RVALID, M_BVALID); end
        clr();
    endtask

    task automatic test_reset_mid();
        do_reset();
        M_AWVALID = 2'b01; M_WVALID = 2'b01; M_BREADY = 2'b01;
        S_AWREADY = 1'b1; S_WREADY = 1'b1; S_BVALID = 1'b1;
        tick();
        tick();
        tick();
        tick();
        S_BVALID = 1'b0;
        tick();
        chk++; if (S_BREADY !== 1'b1) begin fails++; $display("FAIL mid_in_resp: got %0h want 1", S_BREADY); end
        S_BVALID = 1'b1;
        ARESETn = 1'b0;
        #1;
        chk++; if (S_BREADY !== 1'b0 || M_BVALID !== 2'b00) begin fails++; $display("FAIL mid_b: got sb=%0h mb=%0h want 0/0", S_BREADY, M_BVALID); end
        chk++; if (S_AWVALID !== 1'b0 || S_WVALID !== 1'b0 || M_AWREADY !== 2'b00 || M_WREADY !== 2'b00) begin fails++; $display("FAIL mid_aw_w: got %0h %0h %0h %0h want 0", S_AWVALID, S_WVALID, M_AWREADY, M_WREADY); end
        tick();
        ARESETn = 1'b1;
        S_BVALID = 1'b0;
        M_AWVALID = 2'b11; M_WVALID = 2'b11; M_BREADY = 2'b11;
        #1;
        chk++; if (S_AWVALID !== 1'b0) begin fails++; $display("FAIL mid_idle: got %0h want 0", S_AWVALID); end
        tick();
        chk++; if (M_AWREADY !== 2'b01 || M_WREADY !== 2'b01) begin fails++; $display("FAIL mid_grant0: got aw=%0h w=%0h want 1/1", M_AWREADY, M_WREADY); end
        clr();
    endtask

    initial begin
        test_reset();
        test_single_m1();
        test_back_to_back();
        test_wready_delay();
        test_read_rr();
        test_concurrent();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", chk, fails);
        $finish;
    end

endmodule
